// File: rtl/score_keeper.sv
// Game-progress counter: turns collision pulses into score (binary + BCD),
// level and lives, and runs the IDLE/PLAY/OVER state machine.
module score_keeper #(
  parameter int SCORE_W    = 8,
  parameter int LIVES_INIT = 3,
  parameter int LEVEL_STEP = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               enemy_hit,
  input  logic               player_hit,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         bcd_hund,
  output logic [3:0]         bcd_tens,
  output logic [3:0]         bcd_ones,
  output logic [1:0]         lives,
  output logic [3:0]         level,
  output logic               level_up,
  output logic               playing,
  output logic               game_over,
  output logic [1:0]         o_dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam int CNT_W = (LEVEL_STEP < 2) ? 1 : $clog2(LEVEL_STEP + 1);

  logic [1:0]       r_state;
  logic             r_prev_e;
  logic             r_prev_p;
  logic [CNT_W-1:0] r_hit_cnt;

  logic             w_e_edge;
  logic             w_p_edge;
  logic             w_score_max;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_e_edge    = enemy_hit & ~r_prev_e;
  assign w_p_edge    = player_hit & ~r_prev_p;
  assign w_score_max = (score == {SCORE_W{1'b1}});
  assign w_cnt_next  = r_hit_cnt + 1'b1;

  assign playing     = (r_state == S_PLAY);
  assign game_over   = (r_state == S_OVER);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      // History starts high so an input already asserted at release is ignored
      r_prev_e  <= 1'b1;
      r_prev_p  <= 1'b1;
      r_state   <= S_IDLE;
      r_hit_cnt <= '0;
      score     <= '0;
      bcd_hund  <= 4'd0;
      bcd_tens  <= 4'd0;
      bcd_ones  <= 4'd0;
      lives     <= 2'd0;
      level     <= 4'd0;
      level_up  <= 1'b0;
    end else begin
      r_prev_e <= enemy_hit;
      r_prev_p <= player_hit;
      level_up <= 1'b0;
      case (r_state)
        S_PLAY: begin
          if (w_e_edge) begin
            // BCD tracks score incrementally and freezes with it at saturation
            if (!w_score_max) begin
              score <= score + 1'b1;
              if (bcd_ones == 4'd9) begin
                bcd_ones <= 4'd0;
                if (bcd_tens == 4'd9) begin
                  bcd_tens <= 4'd0;
                  bcd_hund <= bcd_hund + 4'd1;
                end else begin
                  bcd_tens <= bcd_tens + 4'd1;
                end
              end else begin
                bcd_ones <= bcd_ones + 4'd1;
              end
            end
            if (w_cnt_next == CNT_W'(LEVEL_STEP)) begin
              r_hit_cnt <= '0;
              if (level != 4'd15) begin
                level    <= level + 4'd1;
                level_up <= 1'b1;
              end
            end else begin
              r_hit_cnt <= w_cnt_next;
            end
          end
          if (w_p_edge) begin
            lives <= lives - 2'd1;
            if (lives == 2'd1) r_state <= S_OVER;
          end
        end
        default: begin
          if (start) begin
            r_state   <= S_PLAY;
            r_hit_cnt <= '0;
            score     <= '0;
            bcd_hund  <= 4'd0;
            bcd_tens  <= 4'd0;
            bcd_ones  <= 4'd0;
            level     <= 4'd0;
            lives     <= 2'(LIVES_INIT);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: score/level/lives derived from a count of enemy hits
// per game, compared every cycle, plus directed literal checks.
module tb_score_keeper;

  logic       clk;
  logic       reset;
  logic       start;
  logic       enemy_hit;
  logic       player_hit;
  logic [7:0] score;
  logic [3:0] bcd_hund, bcd_tens, bcd_ones;
  logic [1:0] lives;
  logic [3:0] level;
  logic       level_up;
  logic       playing;
  logic       game_over;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  score_keeper #(.SCORE_W(8), .LIVES_INIT(3), .LEVEL_STEP(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .enemy_hit  (enemy_hit),
    .player_hit (player_hit),
    .score      (score),
    .bcd_hund   (bcd_hund),
    .bcd_tens   (bcd_tens),
    .bcd_ones   (bcd_ones),
    .lives      (lives),
    .level      (level),
    .level_up   (level_up),
    .playing    (playing),
    .game_over  (game_over),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: the game is described by total enemy hits since start, lives and mode
  int m_mode;      // 0 idle, 1 play, 2 over
  int m_hits;
  int m_lives;
  bit m_lvl_up;
  bit m_prev_e, m_prev_p;
  bit m_valid = 1'b0;

  function automatic int lvl_of(input int hits);
    return (hits / 4 > 15) ? 15 : hits / 4;
  endfunction

  function automatic int score_of(input int hits);
    return (hits > 255) ? 255 : hits;
  endfunction

  always @(posedge clk) begin
    bit e_edge, p_edge;
    int old_lvl;
    e_edge   = enemy_hit && !m_prev_e;
    p_edge   = player_hit && !m_prev_p;
    m_lvl_up = 1'b0;
    if (reset) begin
      m_valid  = 1'b1;
      m_mode   = 0;
      m_hits   = 0;
      m_lives  = 0;
      m_prev_e = 1'b1;
      m_prev_p = 1'b1;
    end else begin
      m_prev_e = enemy_hit;
      m_prev_p = player_hit;
      if (m_mode != 1) begin
        if (start) begin
          m_mode  = 1;
          m_hits  = 0;
          m_lives = 3;
        end
      end else begin
        if (e_edge) begin
          old_lvl = lvl_of(m_hits);
          m_hits++;
          if (lvl_of(m_hits) > old_lvl) m_lvl_up = 1'b1;
        end
        if (p_edge) begin
          m_lives--;
          if (m_lives == 0) m_mode = 2;
        end
      end
    end
  end

  // scoreboard: compare every cycle once reset has been applied
  int lvl_up_seen;
  always @(negedge clk) begin
    if (m_valid) begin
      chk("score",     score,     score_of(m_hits));
      chk("bcd_hund",  bcd_hund,  score_of(m_hits) / 100);
      chk("bcd_tens",  bcd_tens,  (score_of(m_hits) / 10) % 10);
      chk("bcd_ones",  bcd_ones,  score_of(m_hits) % 10);
      chk("lives",     lives,     m_lives);
      chk("level",     level,     lvl_of(m_hits));
      chk("level_up",  level_up,  m_lvl_up);
      chk("playing",   playing,   m_mode == 1);
      chk("game_over", game_over, m_mode == 2);
      if (level_up) lvl_up_seen++;
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_enemy(input int n);
    repeat (n) begin
      enemy_hit = 1'b1; tick();
      enemy_hit = 1'b0; tick();
    end
  endtask

  task automatic pulse_player();
    player_hit = 1'b1; tick();
    player_hit = 1'b0; tick();
  endtask

  task automatic do_start();
    start = 1'b1; tick();
    start = 1'b0;
  endtask

  task automatic new_game();
    reset = 1'b1; tick(2);
    reset = 1'b0;
    do_start();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; enemy_hit = 1'b0; player_hit = 1'b0;
    lvl_up_seen = 0;

    // 1: reset then start
    tick(2);
    chk("rst_score", score, 0);
    chk("rst_playing", playing, 0);
    chk("rst_lives", lives, 0);
    reset = 1'b0;
    do_start();
    chk("t1_playing", playing, 1);
    chk("t1_lives", lives, 3);
    chk("t1_score", score, 0);
    chk("t1_level", level, 0);

    // 2: five pulses then one long hold
    lvl_up_seen = 0;
    pulse_enemy(5);
    enemy_hit = 1'b1; tick(10);
    enemy_hit = 1'b0; tick();
    chk("t2_score", score, 6);
    chk("t2_bcd", {bcd_hund, bcd_tens, bcd_ones}, 12'h006);
    chk("t2_level", level, 1);
    chk("t2_lvlups", lvl_up_seen, 1);
    pulse_enemy(2);  // hit counter was at 2, so two more hits finish level 2
    chk("t2_level2", level, 2);

    // 3: saturation of score and level
    new_game();
    lvl_up_seen = 0;
    pulse_enemy(255);
    chk("t3_score255", score, 255);
    pulse_enemy(3);
    chk("t3_score", score, 255);
    chk("t3_bcd", {bcd_hund, bcd_tens, bcd_ones}, 12'h255);
    chk("t3_level", level, 15);
    chk("t3_lvlups", lvl_up_seen, 15);

    // 4: lose all lives
    pulse_player(); chk("t4_lives2", lives, 2);
    pulse_player(); chk("t4_lives1", lives, 1);
    pulse_player(); chk("t4_lives0", lives, 0);
    chk("t4_over", game_over, 1);
    pulse_enemy(2);
    chk("t4_frozen", score, 255);

    // 5: simultaneous edges on the last life, then restart from OVER
    do_start();
    tick();
    pulse_player(); pulse_player();
    chk("t5_lives1", lives, 1);
    enemy_hit = 1'b1; player_hit = 1'b1; tick();
    chk("t5_score", score, 1);
    chk("t5_lives", lives, 0);
    chk("t5_over", game_over, 1);
    enemy_hit = 1'b0; player_hit = 1'b0; tick();
    do_start();
    chk("t5_rs_score", score, 0);
    chk("t5_rs_lives", lives, 3);
    chk("t5_rs_play", playing, 1);

    // 6: input held through reset release, then reset mid-game
    reset = 1'b1; enemy_hit = 1'b1; tick(2);
    reset = 1'b0;
    do_start();
    tick(3);
    chk("t6_held", score, 0);
    enemy_hit = 1'b0; tick();
    pulse_enemy(9);
    chk("t6_score9", score, 9);
    chk("t6_bcd9", {bcd_hund, bcd_tens, bcd_ones}, 12'h009);
    enemy_hit = 1'b1; reset = 1'b1; tick();
    chk("t6_rst_score", score, 0);
    chk("t6_rst_bcd", {bcd_hund, bcd_tens, bcd_ones}, 12'h000);
    chk("t6_rst_play", playing, 0);
    reset = 1'b0; enemy_hit = 1'b0; tick(3);
    chk("t6_idle_play", playing, 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-progress counter that sits directly upstream of the enemy colour-selection stage.
- Converts collision pulses from the hit-detection logic into a binary score, BCD digits for the HEX displays, a level number, and remaining lives.
- Runs the play/game-over state machine.
- `score` is the value the colour stage consumes; that stage uses `score[1:0]` to rotate the enemy palette.

Parameters:
- SCORE_W, 8, width of the binary score; score saturates at 2^SCORE_W-1.
- LIVES_INIT, 3, lives loaded on game start; legal range 1..3.
- LEVEL_STEP, 4, enemy hits per level increment; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level signal; begins or restarts a game
- enemy_hit  in  1  from collision detector; may be held high for several cycles; only the rising edge counts
- player_hit  in  1  from collision detector; only the rising edge counts
- score  out  SCORE_W  binary score, to the enemy colour stage
- bcd_hund  out  4  score hundreds digit
- bcd_tens  out  4  score tens digit
- bcd_ones  out  4  score ones digit
- lives  out  2  remaining lives
- level  out  4  current level, 0..15
- level_up  out  1  one-cycle pulse when level increments
- playing  out  1  high in PLAY state
- game_over  out  1  high in OVER state

Behaviour:
- Reset (synchronous, active-high; overrides everything):
  - State goes to IDLE.
  - score=0; BCD digits all 0; lives=0; level=0; level_up=0; playing=0; game_over=0; hit-within-level counter=0.
  - Edge-detect history registers reset to 1, so an input already high at reset release is not counted.
- Edge detection:
  - prev_e and prev_p are registered copies of enemy_hit and player_hit, updated every cycle in every state.
  - Edge condition: input=1 and prev=0.
  - Edges seen outside PLAY are discarded.
- States:
  - IDLE:
    - Outputs hold their reset values.
    - start=1 → PLAY.
    - On that transition: score, BCD and level cleared to 0, lives loaded with LIVES_INIT.
  - PLAY:
    - playing=1.
    - enemy edge:
      - score += 1, saturating at 2^SCORE_W-1.
      - BCD updates incrementally in the same cycle as score: ones wraps 9→0 with carry into tens, tens wraps 9→0 with carry into hundreds.
      - No division logic is used.
      - BCD freezes together with score at saturation.
      - The hit-within-level counter increments. When it reaches LEVEL_STEP, it resets to 0, level increments (saturating at 15), and level_up=1 for exactly one cycle.
      - No level_up pulse is generated while level is saturated.
    - player edge:
      - lives -= 1.
      - If the result is 0 → OVER.
  - OVER:
    - game_over=1, playing=0.
    - score, BCD, level and lives (0) are frozen.
    - start=1 → PLAY with the same clear/load as IDLE→PLAY.
- start while in PLAY is ignored.
- Latency: an input edge present at clock edge N updates score/BCD/lives/level and state, all visible after edge N, together with level_up. The minimum latency from input rise is therefore 1 cycle.
- Simultaneous enemy and player edges in the same cycle:
  - Both take effect.
  - The score increment is kept even if lives reach 0 and the state moves to OVER.
- enemy_hit held high: counts once. It must return low for at least one cycle before counting again.
- Reset asserted mid-game: returns to IDLE on the next clock edge regardless of pending edges. The game must be restarted with start.
- All outputs are registered. No combinational path runs from inputs to outputs.

Test Plan:
1. reset=1 for 2 cycles, then start=1 for 1 cycle → playing=1, lives=3, score=0, BCD=000, level=0.
2. In PLAY, 5 separate enemy_hit pulses, then one enemy_hit held high 10 cycles → score=6, BCD=006. level_up pulses once, at the 4th hit; level=1 after the 4th hit; hit-within-level counter=2.
3. Drive 255 pulses, then 3 more → score stops at 255, BCD=255. level increments every 4 hits until 15, then saturates at 15 with no further level_up pulses.
4. 3 player_hit pulses → lives 3→2→1→0. game_over=1 on the cycle after the 3rd edge. Further enemy edges leave score unchanged.
5. enemy_hit and player_hit rise in the same cycle with lives=1 → score+1 and lives=0 both visible next cycle, state OVER. Then start=1 → PLAY, score=0, lives=3.
6. enemy_hit held high through reset release → no increment. Reset pulsed mid-game with score=9 → state IDLE, score=0, BCD=000, playing=0 on the next cycle.
